shake_aes_ctrl: RTL and testbench

Sequencing controller for the SHAKE128 → AES-CBC datapath. It passes seed words from a host into the SHAKE128 absorb port and latches one 128-bit squeezed block as the AES key. It then streams plaintext blocks through the combinational AES core with CBC chaining held internally, and optionally re-squeezes a fresh key every N blocks. It replaces the button-gated input mux at the top level.

---
 rtl/shake_aes_ctrl_pkg.sv | 20 ++
 rtl/shake_aes_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_shake_aes_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// shake_aes_ctrl_pkg : state encoding and datapath widths shared by the
//                      SHAKE128 -> AES-CBC sequencing controller.
// Revision: 1.0
// ============================================================================
package shake_aes_ctrl_pkg;

    localparam int BLK_W  = 128;
    localparam int SEED_W = 64;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ABSORB = 3'd1;
    localparam logic [2:0] ST_SQZ    = 3'd2;
    localparam logic [2:0] ST_READY  = 3'd3;
    localparam logic [2:0] ST_ENC    = 3'd4;
    localparam logic [2:0] ST_OUT    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/shake_aes_ctrl.sv
`default_nettype none
// ============================================================================
// shake_aes_ctrl : feeds a seed into SHAKE128, latches a squeezed AES key and
//                  streams plaintext through an external AES core in CBC mode.
// Revision: 1.0
// ============================================================================
module shake_aes_ctrl
    import shake_aes_ctrl_pkg::*;
#(
    parameter int AES_LAT      = 1,
    parameter int REKEY_BLOCKS = 0,
    parameter int CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic [SEED_W-1:0] i_seed_data,
    input  logic              i_seed_valid,
    input  logic              i_seed_last,
    output logic              o_seed_ready,
    output logic [SEED_W-1:0] o_shk_data,
    output logic              o_shk_valid,
    output logic              o_shk_last,
    input  logic              i_shk_ready,
    input  logic [BLK_W-1:0]  i_shk_data,
    input  logic              i_shk_valid,
    output logic              o_shk_ack,
    input  logic [BLK_W-1:0]  i_iv,
    input  logic [BLK_W-1:0]  i_pt,
    input  logic              i_pt_valid,
    output logic              o_pt_ready,
    output logic [BLK_W-1:0]  o_aes_pt,
    output logic [BLK_W-1:0]  o_aes_iv,
    output logic [BLK_W-1:0]  o_aes_key,
    input  logic [BLK_W-1:0]  i_aes_ct,
    output logic [BLK_W-1:0]  o_ct,
    output logic              o_ct_valid,
    input  logic              i_ct_ready,
    output logic              o_key_valid,
    output logic              o_busy
);

    localparam int               LAT_W     = (AES_LAT > 1) ? $clog2(AES_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(AES_LAT - 1);
    localparam logic [CNT_W-1:0] REKEY_CNT = CNT_W'(REKEY_BLOCKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [2:0]       state_q,     state_d;
    logic [BLK_W-1:0] key_q,       key_d;
    logic [BLK_W-1:0] chain_q,     chain_d;
    logic             first_q,     first_d;
    logic             key_valid_q, key_valid_d;
    logic [CNT_W-1:0] blk_cnt_q,   blk_cnt_d;
    logic [LAT_W-1:0] lat_cnt_q,   lat_cnt_d;
    logic [BLK_W-1:0] aes_pt_q,    aes_pt_d;
    logic [BLK_W-1:0] aes_iv_q,    aes_iv_d;
    logic [BLK_W-1:0] aes_key_q,   aes_key_d;
    logic [BLK_W-1:0] ct_q,        ct_d;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        chain_d      = chain_q;
        first_d      = first_q;
        key_valid_d  = key_valid_q;
        blk_cnt_d    = blk_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        aes_pt_d     = aes_pt_q;
        aes_iv_d     = aes_iv_q;
        aes_key_d    = aes_key_q;
        ct_d         = ct_q;
        o_shk_data   = '0;
        o_shk_valid  = 1'b0;
        o_shk_last   = 1'b0;
        o_seed_ready = 1'b0;
        o_shk_ack    = 1'b0;
        o_pt_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_seed_valid) state_d = ST_ABSORB;
            end
            ST_ABSORB: begin
                o_shk_data   = i_seed_data;
                o_shk_valid  = i_seed_valid;
                o_shk_last   = i_seed_last;
                o_seed_ready = i_shk_ready;
                if (i_seed_valid && i_shk_ready && i_seed_last) begin
                    first_d = 1'b1;
                    state_d = ST_SQZ;
                end
            end
            ST_SQZ: begin
                o_shk_ack = i_shk_valid;
                if (i_shk_valid) begin
                    key_d       = i_shk_data;
                    key_valid_d = 1'b1;
                    blk_cnt_d   = '0;
                    state_d     = ST_READY;
                end
            end
            ST_READY: begin
                o_pt_ready = 1'b1;
                if (i_pt_valid) begin
                    aes_pt_d  = i_pt;
                    aes_key_d = key_q;
                    aes_iv_d  = first_q ? i_iv : chain_q;
                    first_d   = 1'b0;
                    lat_cnt_d = LAT_INIT;
                    state_d   = ST_ENC;
                end
            end
            ST_ENC: begin
                if (lat_cnt_q == '0) begin
                    ct_d    = i_aes_ct;
                    chain_d = i_aes_ct;
                    if (blk_cnt_q != CNT_MAX) blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d = ST_OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_OUT: begin
                // ct_q is only rewritten in ENC, so it stays put under backpressure
                if (i_ct_ready) begin
                    if ((REKEY_BLOCKS != 0) && (blk_cnt_q == REKEY_CNT)) state_d = ST_SQZ;
                    else                                                  state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort also suppresses every handshake so no beat is consumed and lost
        if (i_clear) begin
            state_d      = ST_IDLE;
            key_d        = '0;
            chain_d      = '0;
            first_d      = 1'b0;
            key_valid_d  = 1'b0;
            blk_cnt_d    = '0;
            lat_cnt_d    = '0;
            aes_pt_d     = '0;
            aes_iv_d     = '0;
            aes_key_d    = '0;
            ct_d         = '0;
            o_shk_data   = '0;
            o_shk_valid  = 1'b0;
            o_shk_last   = 1'b0;
            o_seed_ready = 1'b0;
            o_shk_ack    = 1'b0;
            o_pt_ready   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            chain_q     <= '0;
            first_q     <= 1'b0;
            key_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            aes_pt_q    <= '0;
            aes_iv_q    <= '0;
            aes_key_q   <= '0;
            ct_q        <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            chain_q     <= chain_d;
            first_q     <= first_d;
            key_valid_q <= key_valid_d;
            blk_cnt_q   <= blk_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            aes_pt_q    <= aes_pt_d;
            aes_iv_q    <= aes_iv_d;
            aes_key_q   <= aes_key_d;
            ct_q        <= ct_d;
        end
    end

    assign o_aes_pt    = aes_pt_q;
    assign o_aes_iv    = aes_iv_q;
    assign o_aes_key   = aes_key_q;
    assign o_ct        = ct_q;
    assign o_ct_valid  = (state_q == ST_OUT);
    assign o_key_valid = key_valid_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shake_aes_ctrl.sv
`default_nettype none
// ============================================================================
// tb_shake_aes_ctrl : bench for shake_aes_ctrl with stub SHAKE/AES cores and a
//                     block-level CBC reference model.
// Revision: 1.0
// ============================================================================
module tb_shake_aes_ctrl;

    localparam int AES_LAT      = 3;
    localparam int REKEY_BLOCKS = 2;
    localparam int CNT_W        = 16;

    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K38  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV38 = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst, clear;
    logic [63:0]  seed_data;
    logic         seed_valid, seed_last, seed_ready;
    logic [63:0]  shk_data_o;
    logic         shk_valid_o, shk_last_o, shk_ready;
    logic [127:0] sq_key;
    logic         sq_valid, shk_ack;
    logic [127:0] iv, pt;
    logic         pt_valid, pt_ready;
    logic [127:0] aes_pt, aes_iv, aes_key, aes_ct, ct_o;
    logic         ct_valid, ct_ready, key_valid, busy;

    int n_pass  = 0;
    int n_total = 0;
    int ack_cnt = 0;
    int absorb_cnt = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t cbc_vec [4];

    typedef struct {
        logic [127:0] a_pt, a_iv, a_key, ct;
        int           lat;
    } obs_t;

    always #5 clk = ~clk;

    shake_aes_ctrl #(
        .AES_LAT(AES_LAT), .REKEY_BLOCKS(REKEY_BLOCKS), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_seed_data(seed_data), .i_seed_valid(seed_valid), .i_seed_last(seed_last),
        .o_seed_ready(seed_ready),
        .o_shk_data(shk_data_o), .o_shk_valid(shk_valid_o), .o_shk_last(shk_last_o),
        .i_shk_ready(shk_ready),
        .i_shk_data(sq_key), .i_shk_valid(sq_valid), .o_shk_ack(shk_ack),
        .i_iv(iv), .i_pt(pt), .i_pt_valid(pt_valid), .o_pt_ready(pt_ready),
        .o_aes_pt(aes_pt), .o_aes_iv(aes_iv), .o_aes_key(aes_key),
        .i_aes_ct(aes_ct),
        .o_ct(ct_o), .o_ct_valid(ct_valid), .i_ct_ready(ct_ready),
        .o_key_valid(key_valid), .o_busy(busy)
    );

    // Stand-in block cipher; the NIST CBC vectors are served exactly for K38.
    function automatic logic [127:0] toy_enc(input logic [127:0] k, input logic [127:0] x);
        return {x[100:0], x[127:101]} ^ k ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p,
                                             input logic [127:0] v);
        logic [127:0] prev;
        prev = IV38;
        if (k == K38) begin
            for (int i = 0; i < 4; i++) begin
                if ((p ^ v) == (cbc_vec[i].pt ^ prev)) return cbc_vec[i].ct;
                prev = cbc_vec[i].ct;
            end
        end
        return toy_enc(k, p ^ v);
    endfunction

    always_comb aes_ct = aes_ref(aes_key, aes_pt, aes_iv);

    always @(posedge clk) begin
        if (shk_ack) ack_cnt <= ack_cnt + 1;
        if (shk_valid_o && shk_ready) absorb_cnt <= absorb_cnt + 1;
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_seed(input int nwords, input logic [63:0] base);
        int g;
        for (int i = 0; i < nwords; i++) begin
            seed_data  = base + 64'(i);
            seed_valid = 1'b1;
            seed_last  = (i == nwords - 1);
            g = 0;
            @(negedge clk);
            while (!seed_ready && g < 40) begin @(negedge clk); g++; end
            if (!seed_ready) timeout_fail("seed_ready");
            else begin
                check("shk_data_pass", 128'(shk_data_o), 128'(seed_data));
                check("shk_last_pass", 128'(shk_last_o), 128'(seed_last));
            end
            @(posedge clk); #1;
        end
        seed_valid = 1'b0;
        seed_last  = 1'b0;
        g = 0;
        @(negedge clk);
        while (!key_valid && g < 40) begin @(negedge clk); g++; end
        if (!key_valid) timeout_fail("key_valid");
        @(posedge clk); #1;
    endtask

    task automatic send_block(input logic [127:0] p, input logic [127:0] ivv,
                              input int hold, output obs_t o);
        int g;
        o.lat = 0;
        pt = p; iv = ivv; pt_valid = 1'b1; ct_ready = (hold == 0);
        g = 0;
        @(negedge clk);
        while (!pt_ready && g < 40) begin @(negedge clk); g++; end
        if (!pt_ready) timeout_fail("pt_ready");
        @(posedge clk); #1;
        pt_valid = 1'b0;
        pt = rnd128();
        iv = rnd128();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ct_valid) begin o.lat = k; break; end
        end
        if (o.lat == 0) timeout_fail("ct_valid");
        o.ct = ct_o; o.a_pt = aes_pt; o.a_iv = aes_iv; o.a_key = aes_key;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_ct_valid", 128'(ct_valid), 128'(1));
            check("bp_ct_stable", ct_o, o.ct);
            check("bp_pt_ready_low", 128'(pt_ready), 128'(0));
        end
        ct_ready = 1'b1;
        @(posedge clk); #1;
        ct_ready = 1'b0;
        check("ct_single_delivery", 128'(ct_valid), 128'(0));
    endtask

    task automatic check_block(input string tag, input obs_t o, input logic [127:0] p,
                               input logic [127:0] e_key, input logic [127:0] e_iv);
        check({tag, "_aes_pt"},  o.a_pt,  p);
        check({tag, "_aes_key"}, o.a_key, e_key);
        check({tag, "_aes_iv"},  o.a_iv,  e_iv);
        check({tag, "_lat"},     128'(o.lat), 128'(AES_LAT + 1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        logic [127:0] p, prev_ct, e_ct, cur_key, next_key;
        int a0, b0, g, in_key;

        cbc_vec[0] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a, ct: 128'h7649abac8119b246cee98e9b12e9197d};
        cbc_vec[1] = '{pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51, ct: 128'h5086cb9b507219ee95db113a917678b2};
        cbc_vec[2] = '{pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef, ct: 128'h73bed6b8e3c1743b7116e69e22229516};
        cbc_vec[3] = '{pt: 128'hf69f2445df4f9b17ad2b417be66c3710, ct: 128'h3ff1caa1681fac09120eca307586e1a7};

        rst = 1'b1; clear = 1'b0;
        seed_data = '0; seed_valid = 1'b0; seed_last = 1'b0; shk_ready = 1'b1;
        sq_key = K0; sq_valid = 1'b1;
        iv = '0; pt = '0; pt_valid = 1'b0; ct_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_key_valid", 128'(key_valid), 128'(0));
        check("rst_ct_valid", 128'(ct_valid), 128'(0));
        check("rst_outputs", {aes_pt ^ aes_iv ^ aes_key ^ ct_o}, 128'(0));
        check("rst_handshakes", 128'({seed_ready, shk_valid_o, shk_ack, pt_ready}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Session 1: two-word seed, key K0, backpressure, rekey, clear in ENC
        a0 = ack_cnt; b0 = absorb_cnt;
        do_seed(2, 64'h0123456789abcdef);
        check("s1_one_ack", 128'(ack_cnt - a0), 128'(1));
        check("s1_absorb_beats", 128'(absorb_cnt - b0), 128'(2));
        check("s1_key_valid", 128'(key_valid), 128'(1));

        p = {16{8'h11}};
        send_block(p, {16{8'hAA}}, 0, o);
        check_block("b1", o, p, K0, {16{8'hAA}});
        e_ct = toy_enc(K0, p ^ {16{8'hAA}});
        check("b1_ct", o.ct, e_ct);
        prev_ct = e_ct;

        sq_key = 128'hfeedface_0badf00d_13572468_a5a5c3c3;
        p = rnd128();
        send_block(p, rnd128(), 5, o);
        check_block("b2", o, p, K0, prev_ct);
        e_ct = toy_enc(K0, p ^ prev_ct);
        check("b2_ct", o.ct, e_ct);
        prev_ct = e_ct;

        cur_key = sq_key;
        for (int b = 3; b <= 4; b++) begin
            if (b == 4) sq_key = rnd128();
            p = rnd128();
            send_block(p, rnd128(), 0, o);
            check_block("b34", o, p, cur_key, prev_ct);
            e_ct = toy_enc(cur_key, p ^ prev_ct);
            check("b34_ct", o.ct, e_ct);
            prev_ct = e_ct;
        end
        check("s1_rekey_acks", 128'(ack_cnt - a0), 128'(2));

        pt = rnd128(); pt_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!pt_ready && g < 40) begin @(negedge clk); g++; end
        if (!pt_ready) timeout_fail("clr_pt_ready");
        @(posedge clk); #1;
        pt_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_pre_busy", 128'(busy & !ct_valid), 128'(1));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_busy", 128'(busy), 128'(0));
        check("clr_key_valid", 128'(key_valid), 128'(0));
        check("clr_ct_valid", 128'(ct_valid), 128'(0));
        check("clr_outputs", {aes_pt | aes_iv | aes_key | ct_o}, 128'(0));
        check("s1_final_acks", 128'(ack_cnt - a0), 128'(3));

        // Session 2: SP800-38A CBC-AES128 vector, key re-squeezed after block 2
        sq_key = K38;
        a0 = ack_cnt;
        do_seed(3, 64'hc0ffee0000000000);
        for (int i = 0; i < 4; i++) begin
            send_block(cbc_vec[i].pt, IV38, (i == 1) ? 2 : 0, o);
            check_block("nist", o, cbc_vec[i].pt, K38, (i == 0) ? IV38 : cbc_vec[i - 1].ct);
            check("nist_ct", o.ct, cbc_vec[i].ct);
        end
        @(posedge clk); #1;
        check("nist_acks", 128'(ack_cnt - a0), 128'(3));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;

        // Session 3: asynchronous reset while absorbing
        seed_data = 64'h5555aaaa5555aaaa; seed_valid = 1'b1; seed_last = 1'b0;
        g = 0;
        @(negedge clk);
        while (!seed_ready && g < 40) begin @(negedge clk); g++; end
        if (!seed_ready) timeout_fail("rst_abs_ready");
        @(posedge clk); #1;
        @(negedge clk);
        check("abs_busy", 128'(busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 128'(busy), 128'(0));
        check("async_rst_shk", 128'({shk_valid_o, seed_ready}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; seed_valid = 1'b0;
        check("rst_key_valid2", 128'(key_valid), 128'(0));

        // Session 4: random traffic against a block-level CBC/rekey model
        cur_key = rnd128();
        sq_key  = cur_key;
        a0 = ack_cnt;
        do_seed($urandom_range(1, 4), {$urandom(), $urandom()});
        check("rnd_seed_ack", 128'(ack_cnt - a0), 128'(1));
        prev_ct = rnd128();
        in_key = 0;
        next_key = cur_key;
        for (int b = 0; b < 12; b++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (in_key == REKEY_BLOCKS - 1) begin
                next_key = rnd128();
                sq_key   = next_key;
            end
            p = rnd128();
            send_block(p, prev_ct, $urandom_range(0, 3), o);
            check_block("rnd", o, p, cur_key, prev_ct);
            e_ct = toy_enc(cur_key, p ^ prev_ct);
            check("rnd_ct", o.ct, e_ct);
            prev_ct = e_ct;
            in_key++;
            if (in_key == REKEY_BLOCKS) begin
                cur_key = next_key;
                in_key  = 0;
            end
        end
        @(posedge clk); #1;
        check("rnd_acks", 128'(ack_cnt - a0), 128'(1 + 12 / REKEY_BLOCKS));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
